// File: rtl/alu_frame_core_pkg.sv
// Shared types, frame constants and CRC step functions for the frame ALU.
package alu_frame_core_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic DATA_TYPE = 1'b0;
   localparam logic CMD_TYPE  = 1'b1;

   localparam logic [7:0] ERR_DATA_FRAME = 8'hC9;
   localparam logic [7:0] ERR_CRC_FRAME  = 8'hA5;
   localparam logic [7:0] ERR_OP_FRAME   = 8'h93;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b100,
      OP_SUB = 3'b101
   } operation_t;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
   } flags_t;

   typedef enum logic [2:0] {
      COLLECT,
      CHECK,
      SEND_DATA,
      SEND_CTL,
      SEND_ERR
   } state_t;

   // One MSB-first step of CRC x^4+x+1
   function automatic logic [3:0] nextcrc4(input logic [3:0] crc, input logic d);
      logic fb;
      fb = crc[3] ^ d;
      return {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
   endfunction

   // One MSB-first step of CRC x^3+x+1
   function automatic logic [2:0] nextcrc3(input logic [2:0] crc, input logic d);
      logic fb;
      fb = crc[2] ^ d;
      return {crc[1:0], 1'b0} ^ {1'b0, fb, fb};
   endfunction

endpackage

// File: rtl/alu_frame_core_if.sv
// Input and output frame streams of the frame ALU.
interface alu_frame_core_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_type;
   logic [7:0] in_byte;
   logic       out_valid;
   logic       out_ready;
   logic       out_type;
   logic [7:0] out_byte;

   modport master (
      output in_valid, in_type, in_byte, out_ready,
      input  in_ready, out_valid, out_type, out_byte
   );

   modport slave (
      input  in_valid, in_type, in_byte, out_ready,
      output in_ready, out_valid, out_type, out_byte
   );
endinterface

// File: rtl/alu_frame_core_tx.sv
// Output frame buffer: result bytes then control frame, or one error frame.
module alu_frame_core_tx
   import alu_frame_core_pkg::*;
#(
   parameter int unsigned BYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    err,
   input  logic [7:0]              err_byte,
   input  logic [BYTES*BYTE_W-1:0] data,
   input  logic [7:0]              ctl,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic                    out_type,
   output logic [7:0]              out_byte,
   output logic                    fire_c,
   output logic                    last_data_c
);
   localparam int unsigned BUF_W  = (BYTES + 1) * BYTE_W;
   localparam int unsigned LEFT_W = $clog2(BYTES + 1);

   logic [BUF_W-1:0]  frame_buf_q;
   logic [LEFT_W-1:0] left_q;
   logic              valid_q;
   logic              kind_q;

   assign out_valid   = valid_q;
   assign out_type    = kind_q;
   assign out_byte    = frame_buf_q[BUF_W-1 -: BYTE_W];
   assign fire_c      = valid_q && out_ready;
   assign last_data_c = valid_q && (kind_q == DATA_TYPE) && (left_q == LEFT_W'(1));

   // Load a response, then advance one frame per accepted transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_buf_q <= '0;
         left_q      <= '0;
         valid_q     <= 1'b0;
         kind_q      <= DATA_TYPE;
      end else if (load) begin
         valid_q <= 1'b1;
         if (err) begin
            frame_buf_q <= {err_byte, {(BUF_W-BYTE_W){1'b0}}};
            left_q      <= '0;
            kind_q      <= CMD_TYPE;
         end else begin
            frame_buf_q <= {data, ctl};
            left_q      <= LEFT_W'(BYTES);
            kind_q      <= DATA_TYPE;
         end
      end else if (fire_c) begin
         if (left_q != '0) begin
            frame_buf_q <= frame_buf_q << BYTE_W;
            left_q      <= left_q - LEFT_W'(1);
            kind_q      <= (left_q == LEFT_W'(1)) ? CMD_TYPE : DATA_TYPE;
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_frame_core.sv
// Frame ALU: collects B/A/command frames, checks them, emits result or error frames.
module alu_frame_core
   import alu_frame_core_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input logic              clk,
   input logic              rst,
   alu_frame_core_if.slave  bus
);
   localparam int unsigned BYTES   = DATA_W / BYTE_W;
   localparam int unsigned OPND_W  = 2 * DATA_W;
   localparam int unsigned CNT_MAX = 2 * BYTES + 1;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t              state, next_state;
   logic [OPND_W-1:0]   opnd_q;
   logic [CNT_W-1:0]    data_cnt;
   logic [2:0]          op_q;
   logic [3:0]          crc_rx_q;
   logic                in_ready_q;

   logic                in_fire_c, data_fire_c, cmd_fire_c;
   logic [DATA_W-1:0]   b_c, a_c, c_c;
   logic [DATA_W:0]     wide_c;
   flags_t              flags_c;
   logic                op_ok_c;
   logic [OPND_W+3:0]   crc4_msg_c;
   logic [DATA_W+4:0]   crc3_msg_c;
   logic [3:0]          crc4_c;
   logic [2:0]          crc3_c;
   logic                err_c;
   logic [7:0]          err_byte_c;
   logic                tx_load_c, tx_fire_c, tx_last_data_c;
   logic                tx_valid, tx_type;
   logic [7:0]          tx_byte;
   logic                unused_cmd_msb;

   assign in_fire_c      = bus.in_valid && in_ready_q;
   assign data_fire_c    = in_fire_c && (bus.in_type == DATA_TYPE);
   assign cmd_fire_c     = in_fire_c && (bus.in_type == CMD_TYPE);
   assign unused_cmd_msb = bus.in_byte[7];

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = tx_valid;
   assign bus.out_type  = tx_type;
   assign bus.out_byte  = tx_byte;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= COLLECT;
      else     state <= next_state;
   end

   // Next-state logic and response load strobe
   always_comb begin
      next_state = state;
      tx_load_c  = 1'b0;
      case (state)
         COLLECT:   if (cmd_fire_c) next_state = CHECK;
         CHECK: begin
            tx_load_c  = 1'b1;
            next_state = err_c ? SEND_ERR : SEND_DATA;
         end
         SEND_DATA: if (tx_fire_c && tx_last_data_c) next_state = SEND_CTL;
         SEND_CTL:  if (tx_fire_c) next_state = COLLECT;
         SEND_ERR:  if (tx_fire_c) next_state = COLLECT;
         default:   next_state = COLLECT;
      endcase
   end

   // Operand shift-in, frame counting and command capture
   always_ff @(posedge clk) begin
      if (rst) begin
         opnd_q     <= '0;
         data_cnt   <= '0;
         op_q       <= '0;
         crc_rx_q   <= '0;
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= (next_state == COLLECT);
         if (data_fire_c && (data_cnt < CNT_W'(2 * BYTES)))
            opnd_q <= {opnd_q[OPND_W-BYTE_W-1:0], bus.in_byte};
         if (data_fire_c && (data_cnt != CNT_W'(CNT_MAX)))
            data_cnt <= data_cnt + CNT_W'(1);
         if (cmd_fire_c) begin
            op_q     <= bus.in_byte[6:4];
            crc_rx_q <= bus.in_byte[3:0];
         end
         if (state == CHECK)
            data_cnt <= '0;
      end
   end

   // Result and flags
   always_comb begin
      b_c     = opnd_q[OPND_W-1:DATA_W];
      a_c     = opnd_q[DATA_W-1:0];
      wide_c  = '0;
      c_c     = '0;
      flags_c = '0;
      op_ok_c = 1'b1;
      case (op_q)
         OP_AND: c_c = b_c & a_c;
         OP_OR:  c_c = b_c | a_c;
         OP_ADD: begin
            wide_c           = {1'b0, b_c} + {1'b0, a_c};
            c_c              = wide_c[DATA_W-1:0];
            flags_c.carry    = wide_c[DATA_W];
            flags_c.overflow = (b_c[DATA_W-1] == a_c[DATA_W-1]) &&
                               (c_c[DATA_W-1] != b_c[DATA_W-1]);
         end
         OP_SUB: begin
            wide_c           = {1'b0, b_c} - {1'b0, a_c};
            c_c              = wide_c[DATA_W-1:0];
            flags_c.carry    = wide_c[DATA_W];
            flags_c.overflow = (b_c[DATA_W-1] != a_c[DATA_W-1]) &&
                               (c_c[DATA_W-1] != b_c[DATA_W-1]);
         end
         default: op_ok_c = 1'b0;
      endcase
      flags_c.zero     = (c_c == '0);
      flags_c.negative = c_c[DATA_W-1];
   end

   // Input CRC over {B, A, 1, op} and output CRC over {C, 0, flags}
   always_comb begin
      crc4_msg_c = {opnd_q, 1'b1, op_q};
      crc3_msg_c = {c_c, 1'b0, flags_c};
      crc4_c     = '0;
      crc3_c     = '0;
      for (int i = OPND_W + 3; i >= 0; i--) crc4_c = nextcrc4(crc4_c, crc4_msg_c[i]);
      for (int i = DATA_W + 4; i >= 0; i--) crc3_c = nextcrc3(crc3_c, crc3_msg_c[i]);
   end

   // Error selection, frame count first, then CRC, then opcode
   always_comb begin
      err_c      = 1'b1;
      err_byte_c = ERR_DATA_FRAME;
      if (data_cnt != CNT_W'(2 * BYTES)) err_byte_c = ERR_DATA_FRAME;
      else if (crc4_c != crc_rx_q)       err_byte_c = ERR_CRC_FRAME;
      else if (!op_ok_c)                 err_byte_c = ERR_OP_FRAME;
      else                               err_c      = 1'b0;
   end

   alu_frame_core_tx #(.BYTES(BYTES)) u_tx (
      .clk         (clk),
      .rst         (rst),
      .load        (tx_load_c),
      .err         (err_c),
      .err_byte    (err_byte_c),
      .data        (c_c),
      .ctl         ({1'b0, flags_c, crc3_c}),
      .out_ready   (bus.out_ready),
      .out_valid   (tx_valid),
      .out_type    (tx_type),
      .out_byte    (tx_byte),
      .fire_c      (tx_fire_c),
      .last_data_c (tx_last_data_c)
   );

endmodule

// File: tb/tb_alu_frame_core.sv
// Directed bench for alu_frame_core at DATA_W=32 and DATA_W=8.
module tb_alu_frame_core;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_BAD = 3'b010;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [8:0] txq[$];

   always #5 clk = ~clk;

   alu_frame_core_if if32();
   alu_frame_core_if if8();

   alu_frame_core #(.DATA_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
   alu_frame_core #(.DATA_W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));

   // CRC as remainder of polynomial division of msg*x^4 by x^4+x+1
   function automatic logic [3:0] ref_crc4(input logic [63:0] b, input logic [63:0] a,
                                           input int w, input logic [2:0] op);
      logic [139:0] r;
      int len;
      r = '0;
      len = 2 * w + 4;
      for (int i = w - 1; i >= 0; i--) r = {r[138:0], b[i]};
      for (int i = w - 1; i >= 0; i--) r = {r[138:0], a[i]};
      r = {r[138:0], 1'b1};
      for (int i = 2; i >= 0; i--) r = {r[138:0], op[i]};
      r = {r[135:0], 4'b0000};
      for (int i = len + 3; i >= 4; i--)
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      return r[3:0];
   endfunction

   // CRC as remainder of polynomial division of msg*x^3 by x^3+x+1
   function automatic logic [2:0] ref_crc3(input logic [63:0] c, input int w, input logic [3:0] fl);
      logic [79:0] r;
      int len;
      r = '0;
      len = w + 5;
      for (int i = w - 1; i >= 0; i--) r = {r[78:0], c[i]};
      r = {r[78:0], 1'b0};
      for (int i = 3; i >= 0; i--) r = {r[78:0], fl[i]};
      r = {r[76:0], 3'b000};
      for (int i = len + 2; i >= 3; i--)
         if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
      return r[2:0];
   endfunction

   function automatic logic [8:0] ctl_frame(input logic [63:0] c, input int w, input logic [3:0] fl);
      return {1'b1, 1'b0, fl, ref_crc3(c, w, fl)};
   endfunction

   task automatic push_op(input int nbytes, input logic [63:0] b, input logic [63:0] a,
                          input logic [2:0] op, input logic [3:0] crc_xor);
      for (int i = nbytes - 1; i >= 0; i--) txq.push_back({1'b0, b[i*8 +: 8]});
      for (int i = nbytes - 1; i >= 0; i--) txq.push_back({1'b0, a[i*8 +: 8]});
      txq.push_back({1'b1, 1'b0, op, ref_crc4(b, a, nbytes * 8, op) ^ crc_xor});
   endtask

   // Send all queued frames; starts and ends just after a rising edge
   task automatic send_q(input bit w8);
      bit rdy;
      int n;
      for (int i = 0; i < txq.size(); i++) begin
         if (w8) begin
            if8.in_valid = 1'b1; if8.in_type = txq[i][8]; if8.in_byte = txq[i][7:0];
         end else begin
            if32.in_valid = 1'b1; if32.in_type = txq[i][8]; if32.in_byte = txq[i][7:0];
         end
         rdy = 1'b0;
         for (n = 0; n < 100; n++) begin
            @(negedge clk);
            rdy = w8 ? if8.in_ready : if32.in_ready;
            if (rdy) break;
         end
         if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", rdy);
         end
         @(posedge clk); #1;
      end
      if8.in_valid = 1'b0;
      if32.in_valid = 1'b0;
      txq.delete();
   endtask

   // Wait for one accepted output frame; returns just after the accepting edge
   task automatic recv(input bit w8, output logic [8:0] f, output bit ok);
      ok = 1'b0;
      f  = '0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (w8 && if8.out_valid && if8.out_ready) begin
            f = {if8.out_type, if8.out_byte}; ok = 1'b1;
         end else if (!w8 && if32.out_valid && if32.out_ready) begin
            f = {if32.out_type, if32.out_byte}; ok = 1'b1;
         end
         if (ok) break;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({if32.in_ready, if32.out_valid, if32.out_type, if32.out_byte} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs32: got %h required 000", {if32.in_ready, if32.out_valid, if32.out_type, if32.out_byte});
      end
      checks++;
      if ({if8.in_ready, if8.out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs8: got %b required 00", {if8.in_ready, if8.out_valid});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (if32.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_cycle_ready: got %b required 0", if32.in_ready);
      end
      @(negedge clk);
      checks++;
      if ({if32.in_ready, if8.in_ready} !== 2'b11) begin
         errors++;
         $display("FAIL post_reset_ready: got %b required 11", {if32.in_ready, if8.in_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_add_latency;
      logic [8:0] exp[$];
      logic [8:0] f;
      bit ok;
      exp = '{9'h000, 9'h000, 9'h000, 9'h008, ctl_frame(64'h8, 32, 4'b0000)};
      if32.out_ready = 1'b0;
      push_op(4, 64'h5, 64'h3, OP_ADD, 4'h0);
      send_q(1'b0);
      @(negedge clk);
      checks++;
      if ({if32.out_valid, if32.in_ready} !== 2'b00) begin
         errors++;
         $display("FAIL add_check_cycle: valid/ready got %b required 00", {if32.out_valid, if32.in_ready});
      end
      @(negedge clk);
      checks++;
      if (if32.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL add_first_frame_latency: out_valid got %b required 1", if32.out_valid);
      end
      @(posedge clk); #1;
      if32.out_ready = 1'b1;
      foreach (exp[i]) begin
         recv(1'b0, f, ok);
         checks++;
         if (!ok || f !== exp[i]) begin
            errors++;
            $display("FAIL add_frame%0d: got %h (ok=%b) required %h", i, f, ok, exp[i]);
         end
      end
      @(negedge clk);
      checks++;
      if ({if32.out_valid, if32.in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL add_drained: valid/ready got %b required 01", {if32.out_valid, if32.in_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sub;
      logic [8:0] exp[$];
      logic [8:0] f;
      bit ok;
      exp = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h0FE, ctl_frame(64'hFFFF_FFFE, 32, 4'b1001)};
      if32.out_ready = 1'b1;
      push_op(4, 64'h3, 64'h5, OP_SUB, 4'h0);
      send_q(1'b0);
      foreach (exp[i]) begin
         recv(1'b0, f, ok);
         checks++;
         if (!ok || f !== exp[i]) begin
            errors++;
            $display("FAIL sub_frame%0d: got %h (ok=%b) required %h", i, f, ok, exp[i]);
         end
      end
   endtask

   task automatic test_errors;
      logic [8:0] exp_err[6];
      logic [8:0] f;
      bit ok;
      exp_err = '{9'h1C9, 9'h1C9, 9'h1C9, 9'h1A5, 9'h193, 9'h1A5};
      if32.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         case (k)
            0: begin
               for (int i = 0; i < 3; i++) txq.push_back({1'b0, 8'(i + 1)});
               txq.push_back({1'b1, 1'b0, OP_ADD, 4'h0});
            end
            1: begin
               for (int i = 0; i < 9; i++) txq.push_back({1'b0, 8'(i + 1)});
               txq.push_back({1'b1, 1'b0, OP_ADD, 4'h0});
            end
            2: begin
               for (int i = 0; i < 24; i++) txq.push_back({1'b0, 8'(i)});
               txq.push_back({1'b1, 1'b0, OP_ADD, ref_crc4(64'h0001_0203, 64'h0405_0607, 32, OP_ADD)});
            end
            3: push_op(4, 64'h1234_5678, 64'h9ABC_DEF0, OP_ADD, 4'h1);
            4: push_op(4, 64'h1234_5678, 64'h9ABC_DEF0, OP_BAD, 4'h0);
            default: push_op(4, 64'h1234_5678, 64'h9ABC_DEF0, OP_BAD, 4'h1);
         endcase
         send_q(1'b0);
         recv(1'b0, f, ok);
         checks++;
         if (!ok || f !== exp_err[k]) begin
            errors++;
            $display("FAIL err_case%0d: got %h (ok=%b) required %h", k, f, ok, exp_err[k]);
         end
         @(negedge clk);
         checks++;
         if ({if32.out_valid, if32.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL err_single_frame%0d: valid/ready got %b required 01", k, {if32.out_valid, if32.in_ready});
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure8;
      logic [8:0] exp[2];
      logic [8:0] f;
      int idx;
      exp = '{9'h080, ctl_frame(64'h80, 8, 4'b0101)};
      idx = 0;
      if8.out_ready = 1'b0;
      push_op(1, 64'h7F, 64'h01, OP_ADD, 4'h0);
      send_q(1'b1);
      for (int cyc = 0; cyc < 40; cyc++) begin
         if8.out_ready = cyc[1];
         @(negedge clk);
         checks++;
         if (if8.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp8_in_ready cyc%0d: got %b required 0", cyc, if8.in_ready);
         end
         if (if8.out_valid) begin
            f = {if8.out_type, if8.out_byte};
            checks++;
            if (f !== exp[idx]) begin
               errors++;
               $display("FAIL bp8_frame%0d cyc%0d: got %h required %h", idx, cyc, f, exp[idx]);
            end
            if (if8.out_ready) idx++;
         end
         @(posedge clk); #1;
         if (idx == 2) break;
      end
      if8.out_ready = 1'b1;
      checks++;
      if (idx != 2) begin
         errors++;
         $display("FAIL bp8_drain: frames accepted %0d required 2", idx);
      end
      @(negedge clk);
      checks++;
      if ({if8.out_valid, if8.in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp8_done: valid/ready got %b required 01", {if8.out_valid, if8.in_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      logic [8:0] exp[$];
      logic [8:0] f;
      bit ok;
      exp = '{9'h0F0, 9'h000, 9'h0F0, 9'h000, ctl_frame(64'hF000_F000, 32, 4'b0001)};
      if32.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) txq.push_back({1'b0, 8'hA0 + 8'(i)});
      send_q(1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      push_op(4, 64'hF0F0_F0F0, 64'hFF00_FF00, OP_AND, 4'h0);
      send_q(1'b0);
      foreach (exp[i]) begin
         recv(1'b0, f, ok);
         checks++;
         if (!ok || f !== exp[i]) begin
            errors++;
            $display("FAIL rst_collect_frame%0d: got %h (ok=%b) required %h", i, f, ok, exp[i]);
         end
      end
      // reset while the response is pending
      if32.out_ready = 1'b0;
      push_op(4, 64'h1234_5678, 64'h1111_1111, OP_OR, 4'h0);
      send_q(1'b0);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (if32.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_send_pending: out_valid got %b required 1", if32.out_valid);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if32.out_ready = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         checks++;
         if (if32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_send_flush cyc%0d: out_valid got %b required 0", cyc, if32.out_valid);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      if32.in_valid = 1'b0; if32.in_type = 1'b0; if32.in_byte = 8'h00; if32.out_ready = 1'b0;
      if8.in_valid  = 1'b0; if8.in_type  = 1'b0; if8.in_byte  = 8'h00; if8.out_ready  = 1'b0;
      test_reset();
      test_add_latency();
      test_sub();
      test_errors();
      test_backpressure8();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
